// File: rtl/fpga_config_pkg.sv
// fpga_config_pkg: column configuration geometry, loader state encoding and tile slice offsets
package fpga_config_pkg;
  localparam int TILES = 8;
  localparam int TILE_CONFIG_WIDTH = 524;
  localparam int CONFIG_WIDTH = TILES * TILE_CONFIG_WIDTH;
  localparam int WORD_WIDTH = 32;
  localparam int NWORDS = CONFIG_WIDTH / WORD_WIDTH;
  localparam int CNT_W = $clog2(NWORDS);
  typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ACTIVE} state_e;
  function automatic int tile_offset(input int k);
    return k * TILE_CONFIG_WIDTH;
  endfunction
endpackage

// File: rtl/config_shadow_shifter.sv
// config_shadow_shifter: word-wide shift-in shadow register; new words enter at the top
module config_shadow_shifter #(
  parameter int CONFIG_WIDTH = 4192,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    shift_en_i,
  input  logic [WORD_WIDTH-1:0]   data_i,
  output logic [CONFIG_WIDTH-1:0] shadow_o
);
  always_ff @(posedge clock)
    if (reset || clear_i) shadow_o <= '0;
    else if (shift_en_i) shadow_o <= {data_i, shadow_o[CONFIG_WIDTH-1:WORD_WIDTH]};
endmodule

// File: rtl/column_config_loader.sv
// column_config_loader: loads a column image word-serially, commits it atomically and gates fabric reset
module column_config_loader
  import fpga_config_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WORD_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [CONFIG_WIDTH-1:0] config_out,
  output logic                    fabric_nreset,
  output logic                    busy,
  output logic                    done
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);
  if (CONFIG_WIDTH % WORD_WIDTH != 0) begin : g_width_check
    $error("CONFIG_WIDTH must be a multiple of WORD_WIDTH");
  end
  state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CONFIG_WIDTH-1:0] shadow;
  logic xfer, restart;
  assign data_ready = state_q == LOAD;
  assign busy = state_q == LOAD || state_q == COMMIT;
  assign restart = start && state_q != COMMIT;
  // start beats a simultaneous transfer, so that word never reaches the shadow
  assign xfer = data_ready && data_valid && !start;
  config_shadow_shifter #(.CONFIG_WIDTH(CONFIG_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_shadow (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (restart),
    .shift_en_i (xfer),
    .data_i     (data_in),
    .shadow_o   (shadow)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      config_out <= '0;
      fabric_nreset <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          cnt_q <= '0;
        end
        LOAD: if (start) cnt_q <= '0;
          else if (xfer) begin
            if (cnt_q == LAST) state_q <= COMMIT;
            else cnt_q <= cnt_q + 1'b1;
          end
        COMMIT: begin
          config_out <= shadow;
          state_q <= ACTIVE;
        end
        ACTIVE: if (start) begin
          state_q <= LOAD;
          cnt_q <= '0;
          fabric_nreset <= 1'b0;
        end else if (!fabric_nreset) begin
          // release and pulse one cycle after the image lands
          fabric_nreset <= 1'b1;
          done <= 1'b1;
        end
      endcase
    end
endmodule
